// File: rtl/led_ctrl_pkg.sv
// Shared constants and types for the LED chaser step controller.
package led_ctrl_pkg;

  localparam int unsigned SPD_W = 2;

  typedef logic [SPD_W-1:0] speed_t;

  localparam speed_t SPD_SLOW  = 2'd0;
  localparam speed_t SPD_MID   = 2'd1;
  localparam speed_t SPD_BRISK = 2'd2;
  localparam speed_t SPD_FAST  = 2'd3;
  localparam speed_t SPD_MAX   = SPD_FAST;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  localparam logic   RST_RUNNING = 1'b1;
  localparam logic   RST_DIR     = DIR_RIGHT;
  localparam speed_t RST_SPEED   = SPD_SLOW;

  // One press-event bit per button, valid for a single cycle.
  typedef struct packed {
    logic speed;
    logic pause;
    logic dir;
  } press_t;

  function automatic speed_t next_speed(input speed_t s);
    return (s == SPD_MAX) ? SPD_SLOW : speed_t'(s + 2'd1);
  endfunction

endpackage

// File: rtl/led_step_ctrl_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge press pulse
// for one raw pushbutton.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_c
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count while the synced level disagrees; flip once it has held long enough.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_c = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_c = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/led_step_ctrl.sv
// Step-enable prescaler with speed, pause and direction control for the
// 8-LED one-hot chaser.
module led_step_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned BASE_DIV   = 5000000,
  parameter int unsigned CNT_W      = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_speed,
  input  logic             btn_pause,
  input  logic             btn_dir,
  output logic             step,
  output logic             dir,
  output logic             running,
  output logic [SPD_W-1:0] speed
);

  localparam logic [CNT_W-1:0] PERIOD_BASE = CNT_W'(BASE_DIV);

  press_t           press_c;
  logic [CNT_W-1:0] period_c;
  logic [CNT_W-1:0] last_c;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             step_q;
  logic             step_d;
  logic             dir_q;
  logic             dir_d;
  logic             running_q;
  logic             running_d;
  speed_t           speed_q;
  speed_t           speed_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_speed (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_speed),
    .press_c (press_c.speed)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_pause),
    .press_c (press_c.pause)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_dir),
    .press_c (press_c.dir)
  );

  assign period_c = PERIOD_BASE >> speed_q;
  assign last_c   = period_c - CNT_W'(1);

  // A speed press restarts the period; a pause press holds the count so no
  // step is gained or lost across the freeze.
  always_comb begin
    cnt_d     = cnt_q;
    step_d    = 1'b0;
    dir_d     = dir_q;
    running_d = running_q;
    speed_d   = speed_q;

    if (press_c.dir) begin
      dir_d = ~dir_q;
    end
    if (press_c.pause) begin
      running_d = ~running_q;
    end

    if (press_c.speed) begin
      speed_d = next_speed(speed_q);
      cnt_d   = '0;
    end else if (running_q && !press_c.pause) begin
      if (cnt_q == last_c) begin
        cnt_d  = '0;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      step_q    <= 1'b0;
      dir_q     <= RST_DIR;
      running_q <= RST_RUNNING;
      speed_q   <= RST_SPEED;
    end else begin
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      running_q <= running_d;
      speed_q   <= speed_d;
    end
  end

  assign step    = step_q;
  assign dir     = dir_q;
  assign running = running_q;
  assign speed   = speed_q;

endmodule

// File: doc/led_step_ctrl.md
Name: led_step_ctrl

Overview:
- Upstream control stage for the 8-LED one-hot chaser.
- Divides the board clock into a single-cycle step enable with 4 selectable speeds.
- Provides pause/run and shift-direction control from three raw pushbuttons, each debounced and edge-detected.
- The chaser consumes `step` as its clock enable and `dir` as its shift direction.

Parameters:
- DEB_CYCLES, 500000: consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz). Must be ≥ 2.
- BASE_DIV, 5000000: step period in clk cycles at speed 0. Must be ≥ 16.
- CNT_W, 23: prescaler counter width. Must satisfy 2^CNT_W > BASE_DIV.

Ports:
- clk  input  1  board clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_speed  input  1  raw, asynchronous, active-high "next speed" button.
- btn_pause  input  1  raw, asynchronous, active-high pause/run toggle button.
- btn_dir  input  1  raw, asynchronous, active-high direction toggle button.
- step  output  1  one-cycle pulse; the chaser advances one position on it.
- dir  output  1  0 = shift right (MSB→LSB), 1 = shift left.
- running  output  1  1 = steps are generated, 0 = paused.
- speed  output  2  current speed level, 0 (slowest) to 3 (fastest).

Behaviour:

Reset:
- While reset = 1 at a clk edge: step=0, dir=0, running=1, speed=0, prescaler=0.
- Synchronizer flops, debounced levels and debounce counters all go to 0.
- Reset mid-debounce discards the partial count.
- A button still held when reset releases counts as a new press once it has been stable for DEB_CYCLES.

Synchronizer:
- Each button passes through a 2-flop synchronizer.

Debounce, per button:
- Counter increments while synced level ≠ debounced level.
- Counter clears to 0 on any cycle where they are equal.
- When the counter reaches DEB_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
- A 0→1 debounced flip produces a press event in that same edge.
- A clean raw rising edge therefore acts at the (DEB_CYCLES+2)th rising edge after raw is first sampled high.
- Releases produce no event.

Actions on press:
- speed press: speed ← speed+1, wrapping 3→0. Prescaler clears to 0.
- pause press: running toggles. Prescaler holds its value.
- dir press: dir toggles. The prescaler is unaffected.
- Simultaneous presses on different buttons all take effect in the same edge.

Prescaler:
- PERIOD = BASE_DIV >> speed.
- While running=1, the counter counts 0..PERIOD-1.
- In the cycle where the counter == PERIOD-1: step=1 and the counter wraps to 0.
- Steady state: one step every PERIOD cycles.
- While running=0: counter frozen, step=0.
- Resume continues from the frozen count. No step is lost or duplicated across a pause.
- Speed press coinciding with terminal count: the speed change wins, step=0 that cycle, counter←0.
- First step after reset: step=1 in the cycle when the counter reaches BASE_DIV-1, i.e. BASE_DIV cycles after reset deasserts.

Output timing:
- All outputs are registered or decoded directly from registers; there are no combinational paths from button inputs.
- `step` is high for exactly one cycle.

Decomposition:
- Package led_ctrl_pkg holds:
  - speed constants SPD_SLOW=0 … SPD_FAST=3 and SPD_MAX=3;
  - direction constants DIR_RIGHT=0 and DIR_LEFT=1;
  - reset defaults for running, dir and speed.
- One sub-module, btn_debounce (synchronizer + debounce counter + rising-edge press pulse), instantiated three times.
- The prescaler and control registers stay in the top module.

Test Plan (DEB_CYCLES=4, BASE_DIV=16):
- Release reset and hold all buttons low → `step` pulses every 16 cycles, first pulse 16 cycles after reset release; running=1, dir=0, speed=0.
- Hold btn_speed high for 10 cycles → speed=1 at the 6th edge after it is first sampled; step period becomes 8. Three more presses → speed reaches 2, then 3 (period 2), then wraps to 0 (period 16).
- Bounce btn_pause high/low every 2 cycles for 12 cycles, then hold high for 8 → exactly one toggle; running=0, step stays 0. Second clean press → running=1, and the next step arrives after the remaining count from the freeze point.
- Press btn_dir while steps run → dir=1 with step cadence unchanged. Press again → dir=0.
- Time a speed press to land on the edge where the counter=15 → step=0 that cycle, speed=1, next step 8 cycles later.
- Assert reset while btn_speed has been stable for 3 cycles, then deassert reset with btn_speed still held → all outputs at reset values. After 4 more stable cycles (plus synchronizer) → speed=1, exactly one increment.
